// File: rtl/ecc_9_pkg.sv
// rtl/ecc_9_pkg.sv - shared 9/5 SECDED code definitions for the FIFO write encoder and read corrector
package ecc_9_pkg;

    localparam int DATA_W = 9;
    localparam int PAR_W  = 5;
    localparam int CW_W   = DATA_W + PAR_W;

    localparam logic [1:0] INJ_NONE   = 2'b00;
    localparam logic [1:0] INJ_SINGLE = 2'b01;
    localparam logic [1:0] INJ_DOUBLE = 2'b10;

    function automatic logic [PAR_W-1:0] ecc_9_encode(input logic [DATA_W-1:0] d);
        logic [PAR_W-1:0] p;
        p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8];
        p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        p[2] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8];
        p[3] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8];
        p[4] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7];
        return p;
    endfunction

endpackage

// File: rtl/ecc_9_enc_wr_if.sv
// rtl/ecc_9_enc_wr_if.sv - payload in / codeword out stream bundle of the write-side encoder
interface ecc_9_enc_wr_if;
    import ecc_9_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [PAR_W-1:0]  m_parity;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_parity
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_parity
    );

endinterface

// File: rtl/ecc_9_inj_mask.sv
// rtl/ecc_9_inj_mask.sv - turns an injection mode and bit positions into a codeword flip mask
module ecc_9_inj_mask
    import ecc_9_pkg::*;
(
    input  logic [1:0]      mode,
    input  logic [3:0]      pos0,
    input  logic [3:0]      pos1,
    output logic [CW_W-1:0] mask,
    output logic            range_err
);

    // Setting bits rather than toggling makes pos0==pos1 a single flip.
    always_comb begin
        mask      = '0;
        range_err = 1'b0;
        if (mode == INJ_SINGLE || mode == INJ_DOUBLE) begin
            if (pos0 < 4'(CW_W)) mask[pos0] = 1'b1;
            else                 range_err  = 1'b1;
        end
        if (mode == INJ_DOUBLE) begin
            if (pos1 < 4'(CW_W)) mask[pos1] = 1'b1;
            else                 range_err  = 1'b1;
        end
    end

endmodule

// File: rtl/ecc_9_enc_wr.sv
// rtl/ecc_9_enc_wr.sv - FIFO write-side SECDED encoder with 2-entry skid buffer, error injector and counters
module ecc_9_enc_wr
    import ecc_9_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    ecc_9_enc_wr_if.slave      bus,
    input  logic               inj_req,
    input  logic [1:0]         inj_mode,
    input  logic [3:0]         inj_pos0,
    input  logic [3:0]         inj_pos1,
    output logic               inj_armed,
    output logic               inj_done,
    output logic               inj_err,
    output logic [CNT_W-1:0]   enc_cnt,
    output logic [CNT_W-1:0]   inj_cnt
);

    logic [1:0]      cnt;
    logic [1:0]      cnt_next;
    logic [CW_W-1:0] skid_cw;
    logic [1:0]      arm_mode;
    logic [3:0]      arm_pos0;
    logic [3:0]      arm_pos1;
    logic [CW_W-1:0] flip_mask;
    logic            flip_range_err;
    logic            push;
    logic            pop;
    logic            inj_fire;
    logic [CW_W-1:0] new_cw;

    ecc_9_inj_mask u_mask (
        .mode      (arm_mode),
        .pos0      (arm_pos0),
        .pos1      (arm_pos1),
        .mask      (flip_mask),
        .range_err (flip_range_err)
    );

    assign push     = bus.s_valid & bus.s_ready;
    assign pop      = bus.m_valid & bus.m_ready;
    assign inj_fire = push & inj_armed & rst_n;
    assign inj_done = inj_fire;

    // Parity is taken from the clean payload; the flip lands on the whole codeword afterwards.
    assign new_cw = {ecc_9_encode(bus.s_data), bus.s_data} ^ (inj_fire ? flip_mask : '0);

    always_comb begin
        cnt_next = cnt;
        case ({push, pop})
            2'b10:   cnt_next = cnt + 2'd1;
            2'b01:   cnt_next = cnt - 2'd1;
            default: cnt_next = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= 2'd0;
            skid_cw      <= '0;
            bus.s_ready  <= 1'b0;
            bus.m_valid  <= 1'b0;
            bus.m_data   <= '0;
            bus.m_parity <= '0;
            inj_armed    <= 1'b0;
            arm_mode     <= INJ_NONE;
            arm_pos0     <= '0;
            arm_pos1     <= '0;
            inj_err      <= 1'b0;
            enc_cnt      <= '0;
            inj_cnt      <= '0;
        end else begin
            cnt         <= cnt_next;
            bus.s_ready <= (cnt_next < 2'd2);
            bus.m_valid <= (cnt_next != 2'd0);

            // m_* is the head entry; skid_cw holds the second word while the head is stalled.
            if (pop) begin
                if (cnt == 2'd2) begin
                    {bus.m_parity, bus.m_data} <= skid_cw;
                    if (push) skid_cw <= new_cw;
                end else if (push) begin
                    {bus.m_parity, bus.m_data} <= new_cw;
                end
            end else if (push) begin
                if (cnt == 2'd0) {bus.m_parity, bus.m_data} <= new_cw;
                else             skid_cw <= new_cw;
            end

            if (inj_fire) inj_armed <= 1'b0;
            if (inj_req && !inj_armed) begin
                inj_armed <= 1'b1;
                arm_mode  <= inj_mode;
                arm_pos0  <= inj_pos0;
                arm_pos1  <= inj_pos1;
            end
            if ((inj_req && inj_armed) || (inj_fire && flip_range_err)) inj_err <= 1'b1;

            if (push && enc_cnt != '1) enc_cnt <= enc_cnt + 1'b1;
            if (inj_fire && (arm_mode == INJ_SINGLE || arm_mode == INJ_DOUBLE) && inj_cnt != '1)
                inj_cnt <= inj_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ecc_9_enc_wr.sv
// tb/tb_ecc_9_enc_wr.sv - scoreboard bench for the write-side SECDED encoder
module tb_ecc_9_enc_wr;
    import ecc_9_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inj_req = 1'b0;
    logic [1:0]  inj_mode = 2'b00;
    logic [3:0]  inj_pos0 = 4'd0;
    logic [3:0]  inj_pos1 = 4'd0;
    logic        inj_armed;
    logic        inj_done;
    logic        inj_err;
    logic [15:0] enc_cnt;
    logic [15:0] inj_cnt;

    int checks = 0;
    int errors = 0;
    logic [CW_W-1:0] exp_q[$];
    logic [CW_W-1:0] mon_exp;

    always #5 clk = ~clk;

    ecc_9_enc_wr_if bus ();

    ecc_9_enc_wr #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .inj_req   (inj_req),
        .inj_mode  (inj_mode),
        .inj_pos0  (inj_pos0),
        .inj_pos1  (inj_pos1),
        .inj_armed (inj_armed),
        .inj_done  (inj_done),
        .inj_err   (inj_err),
        .enc_cnt   (enc_cnt),
        .inj_cnt   (inj_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n && bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h with empty scoreboard", {bus.m_parity, bus.m_data});
            end else begin
                mon_exp = exp_q.pop_front();
                chk("codeword", 32'({bus.m_parity, bus.m_data}), 32'(mon_exp));
            end
        end
    end

    task automatic send(input logic [8:0] d, input logic [4:0] ep, input logic [8:0] ed, input logic edone);
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        #1;
        while (!bus.s_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: data %h never accepted, required acceptance", d);
        end else begin
            exp_q.push_back({ep, ed});
            chk("inj_done", 32'(inj_done), 32'(edone));
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
    endtask

    task automatic inj(input logic [1:0] mode, input logic [3:0] p0, input logic [3:0] p1);
        inj_req  = 1'b1;
        inj_mode = mode;
        inj_pos0 = p0;
        inj_pos1 = p1;
        @(negedge clk);
        inj_req  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #3;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_m_valid",   32'(bus.m_valid),  32'd0);
        chk("rst_m_data",    32'(bus.m_data),   32'd0);
        chk("rst_m_parity",  32'(bus.m_parity), 32'd0);
        chk("rst_s_ready",   32'(bus.s_ready),  32'd0);
        chk("rst_inj_armed", 32'(inj_armed),    32'd0);
        chk("rst_inj_err",   32'(inj_err),      32'd0);
        chk("rst_enc_cnt",   32'(enc_cnt),      32'd0);
        chk("rst_inj_cnt",   32'(inj_cnt),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("s_ready_after_rst", 32'(bus.s_ready), 32'd1);

        send(9'h000, 5'b00000, 9'h000, 1'b0);
        #1;
        chk("latency_m_valid", 32'(bus.m_valid), 32'd1);
        send(9'h001, 5'b10011, 9'h001, 1'b0);
        send(9'h1FF, 5'b01110, 9'h1FF, 1'b0);

        inj(INJ_SINGLE, 4'd3, 4'd0);
        chk("armed_single", 32'(inj_armed), 32'd1);
        send(9'h000, 5'b00000, 9'h008, 1'b1);
        chk("disarmed_single", 32'(inj_armed), 32'd0);
        inj(INJ_DOUBLE, 4'd0, 4'd9);
        send(9'h000, 5'b00001, 9'h001, 1'b1);
        drain();
        chk("enc_cnt_5", 32'(enc_cnt), 32'd5);
        chk("inj_cnt_2", 32'(inj_cnt), 32'd2);
        chk("inj_err_0", 32'(inj_err), 32'd0);

        bus.m_ready = 1'b0;
        send(9'h001, 5'b10011, 9'h001, 1'b0);
        send(9'h002, 5'b10101, 9'h002, 1'b0);
        #1;
        chk("full_s_ready", 32'(bus.s_ready), 32'd0);
        chk("stall_hold",   32'({bus.m_parity, bus.m_data}), 32'({5'b10011, 9'h001}));
        fork
            begin
                send(9'h004, 5'b10110, 9'h004, 1'b0);
                send(9'h008, 5'b00111, 9'h008, 1'b0);
                send(9'h010, 5'b11001, 9'h010, 1'b0);
                send(9'h0A5, 5'b00011, 9'h0A5, 1'b0);
                send(9'h15A, 5'b01101, 9'h15A, 1'b0);
                send(9'h100, 5'b01101, 9'h100, 1'b0);
            end
            begin
                repeat (2) @(negedge clk);
                bus.m_ready = 1'b1;
            end
        join
        drain();
        chk("enc_cnt_13", 32'(enc_cnt), 32'd13);

        bus.m_ready = 1'b0;
        send(9'h0A5, 5'b00011, 9'h0A5, 1'b0);
        send(9'h15A, 5'b01101, 9'h15A, 1'b0);
        inj(INJ_SINGLE, 4'd0, 4'd0);
        chk("armed_before_rst", 32'(inj_armed), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_m_valid",   32'(bus.m_valid), 32'd0);
        chk("mid_rst_enc_cnt",   32'(enc_cnt),     32'd0);
        chk("mid_rst_inj_cnt",   32'(inj_cnt),     32'd0);
        chk("mid_rst_inj_armed", 32'(inj_armed),   32'd0);
        chk("mid_rst_s_ready",   32'(bus.s_ready), 32'd0);
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        send(9'h001, 5'b10011, 9'h001, 1'b0);
        drain();

        inj(INJ_SINGLE, 4'd5, 4'd0);
        inj(INJ_SINGLE, 4'd7, 4'd0);
        chk("double_req_err",   32'(inj_err),   32'd1);
        chk("double_req_armed", 32'(inj_armed), 32'd1);
        send(9'h000, 5'b00000, 9'h020, 1'b1);
        send(9'h000, 5'b00000, 9'h000, 1'b0);
        drain();
        chk("double_req_inj_cnt", 32'(inj_cnt), 32'd1);
        chk("double_req_enc_cnt", 32'(enc_cnt), 32'd3);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("range_err_pre", 32'(inj_err), 32'd0);
        inj(INJ_SINGLE, 4'd14, 4'd0);
        send(9'h000, 5'b00000, 9'h000, 1'b1);
        drain();
        chk("range_err_set", 32'(inj_err), 32'd1);
        chk("range_inj_cnt", 32'(inj_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
